// File: rtl/memory_access_unit.sv
// Memory access unit: sequences loads, doubleword stores and read-modify-write
// partial stores (sb/sh/sw) against a fixed-latency memory, and exposes the
// memory data register (mdr) to the load extender.
module memory_access_unit #(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] instr,
    input  logic [63:0] addr,
    input  logic [63:0] store_data,
    input  logic [63:0] mem_rdata,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        mem_wr,
    output logic [63:0] mdr,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OP_LOAD   = 2'd0,
        OP_PSTORE = 2'd1,
        OP_SD     = 2'd2,
        OP_BAD    = 2'd3
    } op_e;

    // Counter preset so that RD_WAIT spans exactly READ_LATENCY cycles.
    localparam logic [3:0] WAIT_INIT = 4'(READ_LATENCY - 1);

    // Classify an instruction into the four operation kinds this unit knows.
    function automatic op_e decode_op(input logic [31:0] ins);
        op_e res;
        res = OP_BAD;
        case (ins[6:0])
            7'd3: begin
                if (ins[14:12] != 3'd7) begin
                    res = OP_LOAD;
                end else begin
                    res = OP_BAD;
                end
            end
            7'd35: begin
                case (ins[14:12])
                    3'd0, 3'd1, 3'd2: res = OP_PSTORE;
                    3'd3:             res = OP_SD;
                    default:          res = OP_BAD;
                endcase
            end
            default: res = OP_BAD;
        endcase
        return res;
    endfunction

    // Overlay the low byte/half/word of the store data on the read doubleword.
    function automatic logic [63:0] merge_store(input logic [63:0] rd,
                                                input logic [63:0] sd,
                                                input logic [2:0]  f3);
        logic [63:0] res;
        case (f3)
            3'd0:    res = {rd[63:8],  sd[7:0]};
            3'd1:    res = {rd[63:16], sd[15:0]};
            3'd2:    res = {rd[63:32], sd[31:0]};
            default: res = rd;
        endcase
        return res;
    endfunction

    state_e      state_q;
    op_e         op_q;
    logic [2:0]  funct3_q;
    logic [63:0] addr_q;
    logic [63:0] store_q;
    logic [3:0]  wait_q;
    logic [63:0] mdr_q;
    logic [63:0] mem_wdata_q;
    logic        mem_wr_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;

    op_e         op_in_d;
    logic [63:0] merge_d;
    logic [3:0]  wait_d;
    logic        unused_instr_s;

    // Opcode/funct3 are the only instruction fields this unit looks at.
    assign unused_instr_s = ^{instr[31:15], instr[11:7]};

    // Decode the incoming request and precompute merge / counter next values.
    always_comb begin
        op_in_d = decode_op(instr);
        merge_d = merge_store(mem_rdata, store_q, funct3_q);
        wait_d  = wait_q - 4'd1;
    end

    // Main sequencer: state, captured request and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_LOAD;
            funct3_q    <= 3'd0;
            addr_q      <= 64'd0;
            store_q     <= 64'd0;
            wait_q      <= 4'd0;
            mdr_q       <= 64'd0;
            mem_wdata_q <= 64'd0;
            mem_wr_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q   <= 1'b0;
                    err_q    <= 1'b0;
                    mem_wr_q <= 1'b0;
                    if (start) begin
                        op_q     <= op_in_d;
                        funct3_q <= instr[14:12];
                        addr_q   <= addr;
                        store_q  <= store_data;
                        busy_q   <= 1'b1;
                        case (op_in_d)
                            OP_LOAD, OP_PSTORE: begin
                                state_q     <= ST_RD_WAIT;
                                wait_q      <= WAIT_INIT;
                                mem_wdata_q <= mdr_q;
                            end
                            OP_SD: begin
                                state_q     <= ST_WRITE;
                                mem_wr_q    <= 1'b1;
                                mem_wdata_q <= store_data;
                            end
                            default: begin
                                // Unsupported: report straight away, never write.
                                state_q     <= ST_DONE;
                                done_q      <= 1'b1;
                                err_q       <= 1'b1;
                                mem_wdata_q <= mdr_q;
                            end
                        endcase
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_RD_WAIT: begin
                    if (wait_q == 4'd0) begin
                        mdr_q <= mem_rdata;
                        if (op_q == OP_PSTORE) begin
                            state_q     <= ST_WRITE;
                            mem_wr_q    <= 1'b1;
                            mem_wdata_q <= merge_d;
                        end else begin
                            state_q     <= ST_DONE;
                            done_q      <= 1'b1;
                            mem_wdata_q <= mem_rdata;
                        end
                    end else begin
                        wait_q <= wait_d;
                    end
                end
                ST_WRITE: begin
                    state_q  <= ST_DONE;
                    mem_wr_q <= 1'b0;
                    done_q   <= 1'b1;
                end
                ST_DONE: begin
                    // Any start seen here is dropped; IDLE samples it next cycle.
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    mem_wr_q <= 1'b0;
                    done_q   <= 1'b0;
                    err_q    <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wr    = mem_wr_q;
    assign mdr       = mdr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench: instance A uses READ_LATENCY=2, instance B READ_LATENCY=1.
// Both share the stimulus; each scenario checks the instance it targets.
module tb_memory_access_unit;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] instr;
    logic [63:0] addr;
    logic [63:0] store_data;
    logic [63:0] mem_rdata;

    logic [63:0] a_mem_addr, a_mem_wdata, a_mdr;
    logic        a_mem_wr, a_busy, a_done, a_err;
    logic [63:0] b_mem_addr, b_mem_wdata, b_mdr;
    logic        b_mem_wr, b_busy, b_done, b_err;

    int n_checks;
    int n_fail;
    int a_wr_cnt;
    int b_wr_cnt;

    memory_access_unit #(.READ_LATENCY(2)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .start(start), .instr(instr),
        .addr(addr), .store_data(store_data), .mem_rdata(mem_rdata),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_wr(a_mem_wr),
        .mdr(a_mdr), .busy(a_busy), .done(a_done), .err(a_err)
    );

    memory_access_unit #(.READ_LATENCY(1)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .start(start), .instr(instr),
        .addr(addr), .store_data(store_data), .mem_rdata(mem_rdata),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_wr(b_mem_wr),
        .mdr(b_mdr), .busy(b_busy), .done(b_done), .err(b_err)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count cycles in which each instance drives a write.
    always @(posedge clk) begin
        if (a_mem_wr) a_wr_cnt <= a_wr_cnt + 1;
        if (b_mem_wr) b_wr_cnt <= b_wr_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance through one rising edge and settle just after it.
    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; a_wr_cnt = 0; b_wr_cnt = 0;
        reset_n = 1'b0; start = 1'b0; instr = 32'd0; addr = 64'd0;
        store_data = 64'd0; mem_rdata = 64'd0;

        repeat (2) edge_step();
        check("rst_busy",  {63'd0, a_busy}, 64'd0);
        check("rst_done",  {63'd0, a_done}, 64'd0);
        check("rst_wr",    {63'd0, a_mem_wr}, 64'd0);
        check("rst_mdr",   a_mdr, 64'd0);
        check("rst_addr",  a_mem_addr, 64'd0);
        reset_n = 1'b1;
        edge_step();

        // ld at 0x40 on A (latency 2)
        a_wr_cnt = 0;
        instr = 32'h0000_3003; addr = 64'h40; mem_rdata = 64'hFFEE_DDCC_BBAA_9988; start = 1'b1;
        edge_step();                                   // after E0
        start = 1'b0;
        check("ld_busy_e0", {63'd0, a_busy}, 64'd1);
        check("ld_addr_e0", a_mem_addr, 64'h40);
        check("ld_done_e0", {63'd0, a_done}, 64'd0);
        edge_step();                                   // after E1
        check("ld_done_e1", {63'd0, a_done}, 64'd0);
        edge_step();                                   // after E2
        check("ld_done_e2", {63'd0, a_done}, 64'd1);
        check("ld_err_e2",  {63'd0, a_err}, 64'd0);
        check("ld_mdr_e2",  a_mdr, 64'hFFEE_DDCC_BBAA_9988);
        edge_step();                                   // after E3
        check("ld_done_e3", {63'd0, a_done}, 64'd0);
        check("ld_busy_e3", {63'd0, a_busy}, 64'd0);
        check("ld_nowr",    64'(a_wr_cnt), 64'd0);

        // sb on B (latency 1)
        b_wr_cnt = 0;
        instr = 32'h0000_0023; addr = 64'h80; store_data = 64'h55;
        mem_rdata = 64'h1122_3344_5566_7788; start = 1'b1;
        edge_step();                                   // after E0
        start = 1'b0;
        check("sb_wr_e0",    {63'd0, b_mem_wr}, 64'd0);
        check("sb_busy_e0",  {63'd0, b_busy}, 64'd1);
        edge_step();                                   // after E1
        check("sb_wr_e1",    {63'd0, b_mem_wr}, 64'd1);
        check("sb_wdata_e1", b_mem_wdata, 64'h1122_3344_5566_7755);
        check("sb_mdr_e1",   b_mdr, 64'h1122_3344_5566_7788);
        check("sb_done_e1",  {63'd0, b_done}, 64'd0);
        edge_step();                                   // after E2
        check("sb_wr_e2",    {63'd0, b_mem_wr}, 64'd0);
        check("sb_done_e2",  {63'd0, b_done}, 64'd1);
        check("sb_err_e2",   {63'd0, b_err}, 64'd0);
        edge_step();                                   // after E3
        check("sb_done_e3",  {63'd0, b_done}, 64'd0);
        check("sb_wrcnt",    64'(b_wr_cnt), 64'd1);

        // sd on B: mdr must keep the sb read value
        instr = 32'h0000_3023; addr = 64'h88; store_data = 64'hDEAD_BEEF_0123_4567;
        mem_rdata = 64'hAAAA_AAAA_AAAA_AAAA; start = 1'b1;
        edge_step();                                   // after E0
        start = 1'b0;
        check("sd_wr_e0",    {63'd0, b_mem_wr}, 64'd1);
        check("sd_wdata_e0", b_mem_wdata, 64'hDEAD_BEEF_0123_4567);
        check("sd_addr_e0",  b_mem_addr, 64'h88);
        check("sd_done_e0",  {63'd0, b_done}, 64'd0);
        edge_step();                                   // after E1
        check("sd_done_e1",  {63'd0, b_done}, 64'd1);
        check("sd_wr_e1",    {63'd0, b_mem_wr}, 64'd0);
        check("sd_mdr",      b_mdr, 64'h1122_3344_5566_7788);
        edge_step();

        // unsupported opcode 51 on B, start held into the DONE cycle
        b_wr_cnt = 0;
        instr = 32'h0000_0033; addr = 64'h90; start = 1'b1;
        edge_step();                                   // after E0
        check("bad_done_e0", {63'd0, b_done}, 64'd1);
        check("bad_err_e0",  {63'd0, b_err}, 64'd1);
        check("bad_wr_e0",   {63'd0, b_mem_wr}, 64'd0);
        check("bad_addr_e0", b_mem_addr, 64'h90);
        edge_step();                                   // after E1: start in DONE ignored
        start = 1'b0;
        check("bad_busy_e1", {63'd0, b_busy}, 64'd0);
        check("bad_done_e1", {63'd0, b_done}, 64'd0);
        edge_step();                                   // after E2
        check("bad_busy_e2", {63'd0, b_busy}, 64'd0);
        check("bad_wrcnt",   64'(b_wr_cnt), 64'd0);
        check("bad_mdr",     b_mdr, 64'h1122_3344_5566_7788);

        // let A finish anything it picked up from the shared stimulus
        repeat (6) edge_step();

        // sw on A, reset during RD_WAIT
        a_wr_cnt = 0;
        instr = 32'h0000_2023; addr = 64'hC0; store_data = 64'h1234_5678;
        mem_rdata = 64'h5555_6666_7777_8888; start = 1'b1;
        edge_step();                                   // after E0 -> RD_WAIT
        start = 1'b0;
        check("sw_busy_e0", {63'd0, a_busy}, 64'd1);
        reset_n = 1'b0;
        #2;
        check("rstm_busy",  {63'd0, a_busy}, 64'd0);
        check("rstm_addr",  a_mem_addr, 64'd0);
        check("rstm_mdr",   a_mdr, 64'd0);
        check("rstm_wdata", a_mem_wdata, 64'd0);
        check("rstm_wr",    {63'd0, a_mem_wr}, 64'd0);
        repeat (2) edge_step();
        reset_n = 1'b1;
        edge_step();
        check("rstm_nowr",  64'(a_wr_cnt), 64'd0);

        // lw after reset: A done after E2, B done after E1
        instr = 32'h0000_2003; addr = 64'hD0; mem_rdata = 64'h0123_4567_89AB_CDEF; start = 1'b1;
        edge_step();                                   // after E0
        start = 1'b0;
        edge_step();                                   // after E1
        check("lw_b_done_e1", {63'd0, b_done}, 64'd1);
        check("lw_b_mdr",     b_mdr, 64'h0123_4567_89AB_CDEF);
        check("lw_a_done_e1", {63'd0, a_done}, 64'd0);
        edge_step();                                   // after E2
        check("lw_a_done_e2", {63'd0, a_done}, 64'd1);
        check("lw_a_mdr",     a_mdr, 64'h0123_4567_89AB_CDEF);
        check("lw_a_addr",    a_mem_addr, 64'hD0);
        check("lw_a_nowr",    64'(a_wr_cnt), 64'd0);
        edge_step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
